// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam int unsigned HCNT_W  = 4;
  localparam int unsigned META_AW = 5;

  // Destination/control metadata tracked for each downstream stage.
  typedef struct packed {
    logic               valid;
    logic [META_AW-1:0] rd;
    logic               regwrite;
    logic               memread;
  } stage_meta_t;

  // EX additionally remembers its sources so forwarding can be resolved there.
  typedef struct packed {
    stage_meta_t        meta;
    logic [META_AW-1:0] rs;
    logic [META_AW-1:0] rt;
    logic               use_rs;
    logic               use_rt;
    logic               multi;
  } ex_shadow_t;

  // A stage produces register r; register 0 is never a producer.
  function automatic logic meta_match(input stage_meta_t m, input logic [META_AW-1:0] r);
    return m.valid & m.regwrite & (m.rd == r) & (r != '0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// EX operand forwarding select for one source; the MEM producer wins over WB.
module hazard_fwd_sel
  import hazard_pkg::*;
(
  input  logic [META_AW-1:0] src,
  input  logic               use_src,
  input  stage_meta_t        mem,
  input  stage_meta_t        wb,
  output logic [1:0]         sel
);

  logic unused_memread;
  assign unused_memread = mem.memread ^ wb.memread;

  // Priority select: MEM result, else WB result, else register file.
  always_comb begin
    sel = FWD_RF;
    if (use_src && meta_match(mem, src)) begin
      sel = FWD_MEM;
    end else if (meta_match(wb, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// Optional performance counters are enabled with the HAZ_PERF_EN macro.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = META_AW,
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              id_multi_i,
  input  logic              ex_branch_taken_i,
  output logic              pc_en_o,
  output logic              ifid_en_o,
  output logic              ifid_flush_o,
  output logic              idex_en_o,
  output logic              idex_flush_o,
  output logic              exmem_flush_o,
  output logic              ex_hold_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic              id_byp_a_o,
`ifdef HAZ_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
`endif
  output logic              id_byp_b_o
);

  // The multi-cycle op stays in EX for MULDIV_LAT cycles; LAT=1 loads 0 (no hold).
  localparam logic [HCNT_W-1:0] HOLD_INIT = HCNT_W'(MULDIV_LAT - 1);

`ifndef HAZ_PERF_EN
  localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

  ex_shadow_t        ex_q;
  ex_shadow_t        id_next;
  stage_meta_t       mem_q;
  stage_meta_t       wb_q;
  logic [HCNT_W-1:0] hcnt_q;
  logic              hold;
  logic              branch;
  logic              load_use;

  hazard_fwd_sel u_fwd_a (
    .src     (ex_q.rs),
    .use_src (ex_q.use_rs),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (fwd_a_o)
  );

  hazard_fwd_sel u_fwd_b (
    .src     (ex_q.rt),
    .use_src (ex_q.use_rt),
    .mem     (mem_q),
    .wb      (wb_q),
    .sel     (fwd_b_o)
  );

  // Pack the ID instruction into its EX shadow form.
  always_comb begin
    id_next               = '0;
    id_next.meta.valid    = id_valid_i;
    id_next.meta.rd       = id_rd_i;
    id_next.meta.regwrite = id_regwrite_i;
    id_next.meta.memread  = id_memread_i;
    id_next.rs            = id_rs_i;
    id_next.rt            = id_rt_i;
    id_next.use_rs        = id_use_rs_i;
    id_next.use_rt        = id_use_rt_i;
    id_next.multi         = id_multi_i;
  end

  // Hazard detection and pipeline enable/flush decision, hold > branch > load-use.
  always_comb begin
    hold     = (hcnt_q != '0);
    branch   = ex_branch_taken_i & ex_q.meta.valid;
    load_use = ex_q.meta.valid & ex_q.meta.memread & ex_q.meta.regwrite &
               (ex_q.meta.rd != '0) & id_valid_i &
               ((id_use_rs_i & (id_rs_i == ex_q.meta.rd)) |
                (id_use_rt_i & (id_rt_i == ex_q.meta.rd)));

    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_en_o     = 1'b1;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    ex_hold_o     = hold;

    if (hold) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_en_o     = 1'b0;
      exmem_flush_o = 1'b1;
    end else if (branch) begin
      ifid_flush_o  = 1'b1;
      idex_flush_o  = 1'b1;
    end else if (load_use) begin
      pc_en_o       = 1'b0;
      ifid_en_o     = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  // ID-stage bypass of the value WB is writing this cycle.
  always_comb begin
    id_byp_a_o = id_use_rs_i & meta_match(wb_q, id_rs_i);
    id_byp_b_o = id_use_rt_i & meta_match(wb_q, id_rt_i);
  end

  // Shadow pipeline and multi-cycle hold counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_q   <= '0;
      mem_q  <= '0;
      wb_q   <= '0;
      hcnt_q <= '0;
    end else begin
      wb_q <= mem_q;
      if (hold) begin
        mem_q  <= '0;
        hcnt_q <= hcnt_q - HCNT_W'(1);
      end else begin
        mem_q  <= ex_q.meta;
        hcnt_q <= '0;
        if (idex_flush_o) begin
          ex_q <= '0;
        end else begin
          ex_q <= id_next;
          if (id_valid_i && id_multi_i) begin
            hcnt_q <= HOLD_INIT;
          end
        end
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic stall_evt;
  logic flush_evt;

  // Count effective stall cycles and taken-branch squashes, saturating.
  always_comb begin
    stall_evt = hold | (load_use & ~branch);
    flush_evt = branch & ~hold;
  end

  // Saturating performance counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_evt && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (flush_evt && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MULDIV_LAT=4 and MULDIV_LAT=1).
module tb_pipe_hazard_ctrl;

  localparam logic [6:0] C_NORM = 7'b1101000;
  localparam logic [6:0] C_LU   = 7'b0001100;
  localparam logic [6:0] C_BR   = 7'b1111100;
  localparam logic [6:0] C_HOLD = 7'b0000011;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, id_use_rs, id_use_rt, id_regwrite, id_memread, id_multi;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       branch;

  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, ex_hold;
  logic [1:0] fwd_a, fwd_b;
  logic       byp_a, byp_b;
  logic       pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_flush1, ex_hold1;
  logic [1:0] fwd_a1, fwd_b1;
  logic       byp_a1, byp_b1;
`ifdef HAZ_PERF_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
`endif

  logic [6:0] ctl, ctl1;
  assign ctl  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_flush, ex_hold};
  assign ctl1 = {pc_en1, ifid_en1, ifid_flush1, idex_en1, idex_flush1, exmem_flush1, ex_hold1};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_multi_i(id_multi),
    .ex_branch_taken_i(branch), .pc_en_o(pc_en), .ifid_en_o(ifid_en),
    .ifid_flush_o(ifid_flush), .idex_en_o(idex_en), .idex_flush_o(idex_flush),
    .exmem_flush_o(exmem_flush), .ex_hold_o(ex_hold), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b),
    .id_byp_a_o(byp_a),
`ifdef HAZ_PERF_EN
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt),
`endif
    .id_byp_b_o(byp_b)
  );

  pipe_hazard_ctrl #(.REG_AW(5), .MULDIV_LAT(1), .CNT_W(32)) dut1 (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_rd_i(id_rd),
    .id_regwrite_i(id_regwrite), .id_memread_i(id_memread), .id_multi_i(id_multi),
    .ex_branch_taken_i(branch), .pc_en_o(pc_en1), .ifid_en_o(ifid_en1),
    .ifid_flush_o(ifid_flush1), .idex_en_o(idex_en1), .idex_flush_o(idex_flush1),
    .exmem_flush_o(exmem_flush1), .ex_hold_o(ex_hold1), .fwd_a_o(fwd_a1), .fwd_b_o(fwd_b1),
    .id_byp_a_o(byp_a1),
`ifdef HAZ_PERF_EN
    .stall_cnt_o(stall_cnt1), .flush_cnt_o(flush_cnt1),
`endif
    .id_byp_b_o(byp_b1)
  );

  // A taken branch must never be presented while EX is held.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(ex_hold && branch)) else begin
        bad++;
        $error("FAIL protocol: branch taken during hold");
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mu);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr; id_multi = mu;
    #1;
  endtask

  task automatic idle(input int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1;
    branch = 1'b0;
    set_id(1, 3, 3, 1, 1, 3, 1, 1, 0);
    chk("rst_ctl", 32'(ctl), 32'(C_NORM));
    chk("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    chk("rst_byp", 32'({byp_a, byp_b}), 32'h0);
    tick(); tick();
    rst = 1'b0;
    idle(1);

    // ALU RAW forwarding
    set_id(1, 1, 2, 1, 1, 3, 1, 0, 0);          // add $3
    chk("alu_ctl", 32'(ctl), 32'(C_NORM));
    tick();
    set_id(1, 3, 2, 1, 1, 4, 1, 0, 0);          // sub $4 <- $3
    chk("alu_nostall", 32'(ctl), 32'(C_NORM));
    tick();
    set_id(1, 3, 6, 1, 1, 8, 1, 0, 0);          // or $8 <- $3,$6
    chk("fwd_mem_a", 32'(fwd_a), 32'h2);
    chk("fwd_mem_b", 32'(fwd_b), 32'h0);
    tick();
    set_id(1, 3, 3, 0, 1, 0, 0, 0, 0);          // reads $3 on rt only
    chk("fwd_wb_a", 32'(fwd_a), 32'h1);
    chk("fwd_wb_b", 32'(fwd_b), 32'h0);
    chk("byp_wb", 32'({byp_a, byp_b}), 32'h1);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_none", 32'({fwd_a, fwd_b}), 32'h0);
    tick();
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 0); tick(); // add $9
    set_id(1, 1, 2, 1, 1, 9, 1, 0, 0); tick(); // add $9 again
    set_id(1, 9, 9, 1, 1, 0, 0, 0, 0); tick(); // reader of $9
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_mem_prio", 32'({fwd_a, fwd_b}), 32'hA);
    rst = 1'b1;
    #1;
    chk("rst_clr_fwd", 32'({fwd_a, fwd_b}), 32'h0);
    tick();
    rst = 1'b0;
    idle(1);

    // Load-use interlock
    set_id(1, 1, 0, 1, 0, 5, 1, 1, 0); tick(); // lw $5
    set_id(1, 2, 5, 1, 1, 6, 1, 0, 0);          // add $6 <- $5
    chk("lu_stall", 32'(ctl), 32'(C_LU));
    tick();
    chk("lu_once", 32'(ctl), 32'(C_NORM));
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_b", 32'({fwd_a, fwd_b}), 32'h1);
    chk("lu_after", 32'(ctl), 32'(C_NORM));
    tick();
    set_id(1, 1, 0, 1, 0, 0, 1, 1, 0); tick(); // lw $0
    set_id(1, 0, 0, 1, 1, 6, 1, 0, 0);          // reads $0
    chk("lu_r0", 32'(ctl), 32'(C_NORM));
    tick();
    idle(1);
    set_id(1, 0, 0, 0, 1, 0, 0, 0, 0);          // lw $0 now in WB
    chk("byp_r0", 32'({byp_a, byp_b}), 32'h0);
    idle(3);

    // Taken branch overrides load-use
    set_id(1, 1, 0, 1, 0, 5, 1, 1, 0); tick(); // lw $5
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0);
    branch = 1'b1;
    #1;
    chk("br_flush", 32'(ctl), 32'(C_BR));
    tick();
    chk("br_ex_bubble", 32'(ctl), 32'(C_NORM));
    branch = 1'b0;
    idle(3);

    // Multi-cycle hold
    set_id(1, 1, 2, 1, 1, 10, 1, 0, 1);         // mul $10
    chk("mul_enter", 32'(ctl), 32'(C_NORM));
    tick();
    set_id(1, 10, 0, 1, 0, 11, 1, 0, 0);        // dependent add
    for (int i = 0; i < 3; i++) begin
      chk("mul_hold", 32'(ctl), 32'(C_HOLD));
      chk("lat1_nohold", 32'(ctl1), 32'(C_NORM));
      tick();
    end
    chk("mul_release", 32'(ctl), 32'(C_NORM));
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("mul_left_ex", 32'(fwd_a), 32'h2);
    idle(3);

    // Reset during cycle 2 of a hold
    set_id(1, 1, 2, 1, 1, 12, 1, 0, 1); tick(); // mul $12
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rh_hold1", 32'(ctl), 32'(C_HOLD));
    tick();
    chk("rh_hold2", 32'(ctl), 32'(C_HOLD));
    rst = 1'b1;
    #1;
    chk("rh_abort", 32'(ctl), 32'(C_NORM));
    tick();
    rst = 1'b0;
    idle(1);

`ifdef HAZ_PERF_EN
    chk("perf_rst_stall", stall_cnt, 32'd0);
    chk("perf_rst_flush", flush_cnt, 32'd0);
    set_id(1, 1, 0, 1, 0, 5, 1, 1, 0); tick(); // lw $5
    set_id(1, 5, 0, 1, 0, 6, 1, 0, 0); tick(); // load-use cycle
    set_id(1, 1, 2, 1, 1, 10, 1, 0, 1); tick(); // mul enters EX
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    chk("perf_stall", stall_cnt, 32'd4);
    chk("perf_flush", flush_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
